// File: rtl/sprite_edge_scanner.sv
// Sprite edge scanner: walks the four edges of a sprite box, fetches each
// background pixel from a synchronous frame memory and streams colour,
// coordinates and edge tag with a fixed two-cycle latency from issue.
module sprite_edge_scanner #(
   parameter int unsigned SPRITE_SIZE = 16,
   parameter int unsigned SCREEN_W    = 640,
   parameter int unsigned SCREEN_H    = 480,
   parameter int unsigned ADDR_W      = 19,
   parameter logic [23:0] OOB_COLOR   = 24'hFFFFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [9:0]        ancora_sp_X,
   input  logic [9:0]        ancora_sp_Y,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [23:0]       mem_data,
   output logic [7:0]        R_bg,
   output logic [7:0]        G_bg,
   output logic [7:0]        B_bg,
   output logic [9:0]        ancora_bg_X,
   output logic [9:0]        ancora_bg_Y,
   output logic              pix_valid,
   output logic [1:0]        edge_id,
   output logic              busy,
   output logic              done
);

   localparam int unsigned IDX_W = (SPRITE_SIZE > 1) ? $clog2(SPRITE_SIZE) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SPRITE_SIZE - 1);
   localparam logic [10:0] SIDE_OFS = 11'(SPRITE_SIZE - 1);

   typedef enum logic [1:0] {
      StIdle,
      StScan,
      StDrain
   } state_e;

   // Control state
   state_e           state_q, state_d;
   logic [1:0]       edge_q, edge_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [9:0]       anc_x_q, anc_x_d;
   logic [9:0]       anc_y_q, anc_y_d;
   logic             drain_q, drain_d;
   logic             done_q, done_d;

   // Issue stage (cycle the read is presented to memory)
   logic              mem_rd_q, mem_rd_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              s1_valid_q, s1_valid_d;
   logic              s1_oob_q, s1_oob_d;
   logic [9:0]        s1_x_q, s1_x_d;
   logic [9:0]        s1_y_q, s1_y_d;
   logic [1:0]        s1_edge_q, s1_edge_d;

   // Data-return stage (memory data valid during this stage)
   logic              s2_valid_q, s2_valid_d;
   logic              s2_oob_q, s2_oob_d;
   logic [9:0]        s2_x_q, s2_x_d;
   logic [9:0]        s2_y_q, s2_y_d;
   logic [1:0]        s2_edge_q, s2_edge_d;

   // Output registers
   logic              pix_valid_q, pix_valid_d;
   logic [23:0]       rgb_q, rgb_d;
   logic [9:0]        out_x_q, out_x_d;
   logic [9:0]        out_y_q, out_y_d;
   logic [1:0]        out_edge_q, out_edge_d;

   // Slot selected for issue this cycle
   logic              issue;
   logic [1:0]        slot_edge;
   logic [IDX_W-1:0]  slot_idx;
   logic [9:0]        slot_ax;
   logic [9:0]        slot_ay;
   logic [10:0]       slot_x;
   logic [10:0]       slot_y;
   logic              slot_oob;
   logic [ADDR_W-1:0] slot_addr;

   // FSM next-state: counters point at the slot presented on the memory bus
   always_comb begin
      state_d   = state_q;
      edge_d    = edge_q;
      idx_d     = idx_q;
      anc_x_d   = anc_x_q;
      anc_y_d   = anc_y_q;
      drain_d   = drain_q;
      done_d    = 1'b0;
      issue     = 1'b0;
      slot_edge = edge_q;
      slot_idx  = idx_q;
      slot_ax   = anc_x_q;
      slot_ay   = anc_y_q;
      case (state_q)
         StIdle: begin
            if (start) begin
               // First slot uses the live anchors so it issues in the cycle after start
               anc_x_d   = ancora_sp_X;
               anc_y_d   = ancora_sp_Y;
               edge_d    = 2'd0;
               idx_d     = '0;
               issue     = 1'b1;
               slot_edge = 2'd0;
               slot_idx  = '0;
               slot_ax   = ancora_sp_X;
               slot_ay   = ancora_sp_Y;
               state_d   = StScan;
            end
         end
         StScan: begin
            if (edge_q == 2'd3 && idx_q == IDX_LAST) begin
               state_d = StDrain;
               edge_d  = 2'd0;
               idx_d   = '0;
               drain_d = 1'b0;
            end else begin
               issue = 1'b1;
               if (idx_q == IDX_LAST) begin
                  idx_d  = '0;
                  edge_d = edge_q + 2'd1;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
               slot_edge = edge_d;
               slot_idx  = idx_d;
            end
         end
         StDrain: begin
            if (drain_q) begin
               state_d = StIdle;
               drain_d = 1'b0;
               done_d  = 1'b1;
            end else begin
               drain_d = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Slot coordinates (11-bit, no wrap), screen bounds test and linear address
   always_comb begin
      logic [10:0] ax;
      logic [10:0] ay;
      logic [10:0] off;
      ax  = {1'b0, slot_ax};
      ay  = {1'b0, slot_ay};
      off = 11'(slot_idx);
      case (slot_edge)
         2'd0: begin
            slot_x = ax;
            slot_y = ay + off;
         end
         2'd1: begin
            slot_x = ax + SIDE_OFS;
            slot_y = ay + off;
         end
         2'd2: begin
            slot_x = ax + off;
            slot_y = ay + SIDE_OFS;
         end
         default: begin
            slot_x = ax + off;
            slot_y = ay;
         end
      endcase
      slot_oob  = (32'(slot_x) >= SCREEN_W) || (32'(slot_y) >= SCREEN_H);
      slot_addr = ADDR_W'(32'(slot_y) * SCREEN_W + 32'(slot_x));
   end

   // Issue and pipeline next-state; off-screen slots skip the read but keep their slot
   always_comb begin
      mem_rd_d   = issue & ~slot_oob;
      mem_addr_d = (issue && !slot_oob) ? slot_addr : mem_addr_q;
      s1_valid_d = issue;
      s1_oob_d   = slot_oob;
      s1_x_d     = slot_x[9:0];
      s1_y_d     = slot_y[9:0];
      s1_edge_d  = slot_edge;

      s2_valid_d = s1_valid_q;
      s2_oob_d   = s1_oob_q;
      s2_x_d     = s1_x_q;
      s2_y_d     = s1_y_q;
      s2_edge_d  = s1_edge_q;

      pix_valid_d = s2_valid_q;
      rgb_d       = rgb_q;
      out_x_d     = out_x_q;
      out_y_d     = out_y_q;
      out_edge_d  = out_edge_q;
      if (s2_valid_q) begin
         rgb_d      = s2_oob_q ? OOB_COLOR : mem_data;
         out_x_d    = s2_x_q;
         out_y_d    = s2_y_q;
         out_edge_d = s2_edge_q;
      end
   end

   // State registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StIdle;
         edge_q      <= 2'd0;
         idx_q       <= '0;
         anc_x_q     <= 10'd0;
         anc_y_q     <= 10'd0;
         drain_q     <= 1'b0;
         done_q      <= 1'b0;
         mem_rd_q    <= 1'b0;
         mem_addr_q  <= '0;
         s1_valid_q  <= 1'b0;
         s1_oob_q    <= 1'b0;
         s1_x_q      <= 10'd0;
         s1_y_q      <= 10'd0;
         s1_edge_q   <= 2'd0;
         s2_valid_q  <= 1'b0;
         s2_oob_q    <= 1'b0;
         s2_x_q      <= 10'd0;
         s2_y_q      <= 10'd0;
         s2_edge_q   <= 2'd0;
         pix_valid_q <= 1'b0;
         rgb_q       <= 24'd0;
         out_x_q     <= 10'd0;
         out_y_q     <= 10'd0;
         out_edge_q  <= 2'd0;
      end else begin
         state_q     <= state_d;
         edge_q      <= edge_d;
         idx_q       <= idx_d;
         anc_x_q     <= anc_x_d;
         anc_y_q     <= anc_y_d;
         drain_q     <= drain_d;
         done_q      <= done_d;
         mem_rd_q    <= mem_rd_d;
         mem_addr_q  <= mem_addr_d;
         s1_valid_q  <= s1_valid_d;
         s1_oob_q    <= s1_oob_d;
         s1_x_q      <= s1_x_d;
         s1_y_q      <= s1_y_d;
         s1_edge_q   <= s1_edge_d;
         s2_valid_q  <= s2_valid_d;
         s2_oob_q    <= s2_oob_d;
         s2_x_q      <= s2_x_d;
         s2_y_q      <= s2_y_d;
         s2_edge_q   <= s2_edge_d;
         pix_valid_q <= pix_valid_d;
         rgb_q       <= rgb_d;
         out_x_q     <= out_x_d;
         out_y_q     <= out_y_d;
         out_edge_q  <= out_edge_d;
      end
   end

   assign mem_rd      = mem_rd_q;
   assign mem_addr    = mem_addr_q;
   assign R_bg        = rgb_q[23:16];
   assign G_bg        = rgb_q[15:8];
   assign B_bg        = rgb_q[7:0];
   assign ancora_bg_X = out_x_q;
   assign ancora_bg_Y = out_y_q;
   assign pix_valid   = pix_valid_q;
   assign edge_id     = out_edge_q;
   assign busy        = (state_q != StIdle);
   assign done        = done_q;

endmodule

// File: tb/tb_sprite_edge_scanner.sv
// Scoreboard bench for sprite_edge_scanner: the driver pushes the expected
// issue/pixel/done stream for each accepted scan, a negedge monitor pops and
// compares whatever the DUT presents.
module tb_sprite_edge_scanner;

   logic        clk;
   logic        rst;
   logic        start;
   logic [9:0]  sp_x;
   logic [9:0]  sp_y;
   logic        mem_rd;
   logic [18:0] mem_addr;
   logic [23:0] mem_data;
   logic [7:0]  r_bg;
   logic [7:0]  g_bg;
   logic [7:0]  b_bg;
   logic [9:0]  bg_x;
   logic [9:0]  bg_y;
   logic        pix_valid;
   logic [1:0]  edge_id;
   logic        busy;
   logic        done;

   sprite_edge_scanner dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .ancora_sp_X(sp_x),
      .ancora_sp_Y(sp_y),
      .mem_rd     (mem_rd),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .R_bg       (r_bg),
      .G_bg       (g_bg),
      .B_bg       (b_bg),
      .ancora_bg_X(bg_x),
      .ancora_bg_Y(bg_y),
      .pix_valid  (pix_valid),
      .edge_id    (edge_id),
      .busy       (busy),
      .done       (done)
   );

   typedef struct {
      int          cyc;
      logic        rd;
      logic [18:0] addr;
   } iss_t;

   typedef struct {
      int          cyc;
      logic [23:0] rgb;
      logic [9:0]  x;
      logic [9:0]  y;
      logic [1:0]  eid;
   } pix_t;

   iss_t iq[$];
   pix_t pq[$];
   int   dq[$];

   int          cyc = 0;
   int          n_pass = 0;
   int          n_total = 0;
   int          busy_lo = 1;
   int          busy_hi = 0;
   int          zero_cyc = -1;
   bit          mon_en = 1'b0;
   logic [18:0] last_addr = '0;
   logic [45:0] last_pix = '0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Memory returns its own address as colour; junk when not read
   always @(posedge clk) begin
      if (mem_rd === 1'b1) mem_data <= {5'd0, mem_addr};
      else mem_data <= 24'($urandom);
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
   endtask

   // Reference model: every edge pixel of one scan, from the edge definitions
   task automatic push_scan(input int s, input int ax, input int ay);
      int k;
      k = 0;
      busy_lo = s;
      busy_hi = s + 65;
      for (int e = 0; e < 4; e++) begin
         for (int i = 0; i < 16; i++) begin
            int x, y, a;
            bit oob;
            case (e)
               0: begin x = ax;      y = ay + i;  end
               1: begin x = ax + 15; y = ay + i;  end
               2: begin x = ax + i;  y = ay + 15; end
               default: begin x = ax + i; y = ay; end
            endcase
            oob = (x >= 640) || (y >= 480);
            a = y * 640 + x;
            iq.push_back('{s + k, !oob, oob ? last_addr : a[18:0]});
            if (!oob) last_addr = a[18:0];
            pq.push_back('{s + k + 2, oob ? 24'hFFFFFF : a[23:0], x[9:0], y[9:0], e[1:0]});
            k++;
         end
      end
      dq.push_back(s + 66);
   endtask

   task automatic tick();
      if (!start) begin
         sp_x = 10'($urandom);
         sp_y = 10'($urandom);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input int ax, input int ay);
      int  c;
      bit  acc;
      c   = cyc;
      acc = !(c >= busy_lo && c <= busy_hi);
      start = 1'b1;
      sp_x = 10'(ax);
      sp_y = 10'(ay);
      tick();
      start = 1'b0;
      if (acc) push_scan(cyc, ax, ay);
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (cyc <= busy_hi + 1 && n < 300) begin
         tick();
         n++;
      end
      if (n >= 300) check("idle_timeout", 128'(n), 128'(0));
   endtask

   task automatic flush_after_reset();
      iq.delete();
      pq.delete();
      dq.delete();
      busy_lo = 1;
      busy_hi = 0;
      last_addr = '0;
      last_pix = '0;
      zero_cyc = cyc;
   endtask

   // Monitor: compares DUT outputs against the queued expectations
   always @(negedge clk) begin
      if (mon_en) begin
         if (cyc == zero_cyc)
            check("reset_zero", 128'({mem_rd, mem_addr, r_bg, g_bg, b_bg, bg_x, bg_y,
                                      pix_valid, edge_id, busy, done}), 128'(0));
         check("busy", 128'(busy), 128'(cyc >= busy_lo && cyc <= busy_hi));
         if (iq.size() > 0 && iq[0].cyc == cyc) begin
            iss_t it;
            it = iq.pop_front();
            check("mem_issue", 128'({mem_rd, mem_addr}), 128'({it.rd, it.addr}));
         end else begin
            check("mem_idle", 128'({mem_rd, mem_addr}), 128'({1'b0, last_addr}));
         end
         if (pix_valid) begin
            if (pq.size() == 0) begin
               check("pix_unexpected", 128'(1), 128'(0));
            end else begin
               pix_t p;
               p = pq.pop_front();
               check("pix_cycle", 128'(cyc), 128'(p.cyc));
               check("pix_data", 128'({r_bg, g_bg, b_bg, bg_x, bg_y, edge_id}),
                     128'({p.rgb, p.x, p.y, p.eid}));
               last_pix = {p.rgb, p.x, p.y, p.eid};
            end
         end else begin
            check("pix_hold", 128'({r_bg, g_bg, b_bg, bg_x, bg_y, edge_id}), 128'(last_pix));
            if (pq.size() > 0 && pq[0].cyc < cyc) begin
               pix_t p;
               p = pq.pop_front();
               check("pix_missing", 128'(cyc), 128'(p.cyc));
            end
         end
         if (done) begin
            if (dq.size() == 0) check("done_unexpected", 128'(1), 128'(0));
            else check("done_cycle", 128'(cyc), 128'(dq.pop_front()));
         end else if (dq.size() > 0 && dq[0] < cyc) begin
            check("done_missing", 128'(cyc), 128'(dq.pop_front()));
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed",
               n_pass, n_total);
      $fatal(1);
   end

   initial begin
      int s;
      rst   = 1'b1;
      start = 1'b0;
      sp_x  = '0;
      sp_y  = '0;
      repeat (3) tick();
      rst = 1'b0;
      flush_after_reset();
      mon_en = 1'b1;
      repeat (2) tick();

      // Directed scans: nominal, bottom-right OOB, X overflow past 1023
      pulse_start(100, 50);
      wait_idle();
      pulse_start(630, 470);
      wait_idle();
      pulse_start(1020, 0);
      wait_idle();

      // Reset in cycle 30 of a scan, then a fresh scan
      pulse_start(int'($urandom_range(0, 700)), int'($urandom_range(0, 500)));
      s = busy_lo;
      while (cyc < s + 29) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      flush_after_reset();
      repeat (4) tick();
      pulse_start(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
      wait_idle();

      // Ignored starts at cycles 10 and 40, accepted start on the done cycle
      pulse_start(200, 100);
      s = busy_lo;
      while (cyc < s + 9) tick();
      pulse_start(5, 5);
      while (cyc < s + 39) tick();
      pulse_start(7, 7);
      while (cyc < s + 66) tick();
      pulse_start(300, 200);
      wait_idle();

      // Random scans with stray starts while busy
      for (int r = 0; r < 8; r++) begin
         repeat ($urandom_range(0, 3)) tick();
         pulse_start(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
         if (r % 2 == 1) begin
            repeat ($urandom_range(5, 50)) tick();
            pulse_start(int'($urandom_range(0, 1023)), int'($urandom_range(0, 1023)));
         end
         wait_idle();
      end

      repeat (5) tick();
      if (iq.size() != 0) check("issue_leftover", 128'(iq.size()), 128'(0));
      if (pq.size() != 0) check("pix_leftover", 128'(pq.size()), 128'(0));
      if (dq.size() != 0) check("done_leftover", 128'(dq.size()), 128'(0));
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/sprite_edge_scanner.md
Name: sprite_edge_scanner

Overview:
- Producer of the background pixel stream that feeds the per-edge colour statistics block.
- On `start`, latches the sprite anchor and walks the four 16-pixel edges of the sprite box, 64 reads in total.
- Fetches each pixel from the synchronous background frame memory.
- Emits colour, coordinate and edge tag with a valid strobe, then pulses `done`.

Parameters:
SPRITE_SIZE, 16, edge length in pixels; the counter spans 0..SPRITE_SIZE-1.
SCREEN_W, 640, frame width; also the row stride used in address computation.
SCREEN_H, 480, frame height.
ADDR_W, 19, background memory address width.
OOB_COLOR, 24'hFFFFFF, {R,G,B} emitted for pixels outside the screen.

Ports:
clk  in  1  system clock
rst  in  1  reset, synchronous, active-high
start  in  1  begin one scan; sampled only in IDLE
ancora_sp_X  in  10  sprite anchor X, latched on accepted start
ancora_sp_Y  in  10  sprite anchor Y, latched on accepted start
mem_rd  out  1  registered read strobe to background memory
mem_addr  out  ADDR_W  registered read address, y*SCREEN_W+x
mem_data  in  24  {R,G,B}, valid the cycle after mem_rd is sampled
R_bg  out  8  pixel red
G_bg  out  8  pixel green
B_bg  out  8  pixel blue
ancora_bg_X  out  10  pixel X, 10 LSBs
ancora_bg_Y  out  10  pixel Y, 10 LSBs
pix_valid  out  1  R/G/B/coords/edge_id valid this cycle
edge_id  out  2  0: X=sp_X, Y sweep; 1: X=sp_X+15, Y sweep; 2: Y=sp_Y+15, X sweep; 3: Y=sp_Y, X sweep
busy  out  1  scan in progress
done  out  1  one-cycle pulse after last pixel

Behaviour:
- Reset (any state, including mid-scan):
  - State → IDLE.
  - All outputs 0.
  - Edge and index counters 0.
  - In-flight pipeline valids cleared; memory data returning after reset is discarded.
- States: IDLE, SCAN, DRAIN.
  - IDLE: `start`=1 → latch anchors, go to SCAN.
  - SCAN: issue one pixel per cycle.
    - Index 0..15 inner, edge 0..3 outer; sweep coordinate = anchor + index.
    - After edge 3 index 15 → DRAIN.
  - DRAIN: exactly 2 cycles → IDLE, with `done`=1 in the first IDLE cycle.
- Timing, with `start` sampled at edge of cycle 0:
  - `busy`=1 cycles 1..66.
  - `mem_rd`/`mem_addr` issue cycles 1..64.
  - `pix_valid`=1 cycles 3..66; each pixel has fixed 2-cycle latency from issue.
  - `done`=1 cycle 67.
- `start` during SCAN/DRAIN is ignored. `start` coincident with `done` (cycle 67) is accepted: `busy` rises cycle 68.
- Coordinates are computed 11 bits wide: sp+index with no wrap.
  - Out-of-screen pixel (x>=SCREEN_W or y>=SCREEN_H):
    - `mem_rd`=0 for that slot, `mem_addr` holds its previous value.
    - Emitted with OOB_COLOR on its normal output slot; ordering and latency are unchanged.
  - Emitted `ancora_bg_X`/`ancora_bg_Y` are the 10 LSBs of the 11-bit sum.
- `mem_addr` = y*SCREEN_W + x computed in ADDR_W bits; the multiply is by constant stride.
- When `pix_valid`=0, R/G/B, coords and `edge_id` hold their last values.
- Corner pixels are emitted once per edge that contains them (4 corners × 2). No deduplication.
- Anchor inputs changing during a scan have no effect.

Test Plan:
- rst held 3 cycles, then released → all outputs 0, IDLE. `start`=1 with sp=(100,50) → `busy` 1..66; 64 `pix_valid` cycles.
  - First pixel (100,50) edge 0 with `mem_addr`=32100.
  - Pixel 17 is (115,50) edge 1.
  - Last pixel (115,50) edge 3; `done` pulse cycle 67.
- Memory model returns data=addr[23:0] → every emitted {R,G,B} equals y*640+x of its coordinates; 2-cycle latency from issue.
- sp=(630,470) → x>=640 or y>=480 slots have `mem_rd`=0 and colour FFFFFF. Edge 1 is entirely OOB (x=645), as is edge 2 (y=485). Total still 64 pixels; `done` at cycle 67.
- Reset and start races:
  - `rst` asserted cycle 30 mid-scan → next cycle all outputs 0; no `pix_valid` or `done` afterward.
  - A fresh `start` completes normally.
- `start` pulses at cycles 10 and 40 of a scan → ignored, exactly one `done`. `start` at `done` cycle → second scan, `busy` from cycle 68.
- sp=(1020,0) → X sums 1020..1035 flagged OOB; emitted X LSBs wrap to 1020..1023, 0..11.
